alu_cmd_sequencer: RTL and testbench

//  Command-side driver for the 8-bit combinational ALU. Accepts one ALU command
//  per valid/ready handshake and drives the ALU's A/B/Cin/Mode inputs from registers.

---
 rtl/alu_cmd_sequencer.sv | 117 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command-side driver for an 8-bit combinational ALU. It accepts one command
//   per valid/ready handshake and drives the ALU operand, carry-in and mode
//   inputs from registers. It then captures the ALU result and flags and
//   returns them on a valid/ready response channel. A stored carry lets
//   multi-byte add/subtract chains (LSB first) run without software help.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_a, cmd_b, cmd_cin,
//   cmd_chain, cmd_mode             command payload (cmd_chain selects carry_q as Cin)
//   alu_a, alu_b, alu_cin, alu_mode registered ALU inputs
//   alu_result, alu_ovf, alu_zero,
//   alu_neg, alu_carry              ALU outputs
//   rsp_valid/rsp_ready             response handshake
//   rsp_result, rsp_flags           captured result and {ovf, zero, neg, carry}
//   sticky_ovf, sticky_clr          accumulated overflow flag and its clear
//   carry_q                         stored carry/borrow for chaining
//   ops_done                        completed responses, saturating

module alu_cmd_sequencer #(
    parameter int DATA_W = 8,
    parameter int MODE_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_cin,
    input  logic              cmd_chain,
    input  logic [MODE_W-1:0] cmd_mode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    output logic [MODE_W-1:0] alu_mode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovf,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              sticky_ovf,
    input  logic              sticky_clr,
    output logic              carry_q,
    output logic [CNT_W-1:0]  ops_done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0] state;

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
            alu_mode   <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            carry_q    <= 1'b0;
            ops_done   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a    <= cmd_a;
                        alu_b    <= cmd_b;
                        alu_mode <= cmd_mode;
                        alu_cin  <= cmd_chain ? carry_q : cmd_cin;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // ALU inputs have been stable for the whole cycle; sample now.
                    rsp_result <= alu_result;
                    rsp_flags  <= {alu_ovf, alu_zero, alu_neg, alu_carry};
                    carry_q    <= alu_carry;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        if (ops_done != '1) begin
                            ops_done <= ops_done + CNT_W'(1);
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A capture with overflow takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
        end else if (state == ISSUE && alu_ovf) begin
            sticky_ovf <= 1'b1;
        end else if (sticky_clr) begin
            sticky_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
//   Self-checking bench: a small ALU model answers the sequencer's ALU inputs,
//   expected responses are queued when commands are issued and compared as
//   responses arrive.

module tb_alu_cmd_sequencer;

    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_a = '0;
    logic [7:0] cmd_b = '0;
    logic       cmd_cin = 1'b0;
    logic       cmd_chain = 1'b0;
    logic [3:0] cmd_mode = '0;
    logic [7:0] alu_a, alu_b;
    logic       alu_cin;
    logic [3:0] alu_mode;
    logic [7:0] alu_result;
    logic       alu_ovf, alu_zero, alu_neg, alu_carry;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_result;
    logic [3:0] rsp_flags;
    logic       sticky_ovf;
    logic       sticky_clr = 1'b0;
    logic       carry_q;
    logic [CNT_W-1:0] ops_done;

    alu_cmd_sequencer #(.DATA_W(8), .MODE_W(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .cmd_chain(cmd_chain), .cmd_mode(cmd_mode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_mode(alu_mode),
        .alu_result(alu_result), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
        .alu_neg(alu_neg), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr),
        .carry_q(carry_q), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // Returns {ovf, zero, neg, carry, result[7:0]}.
    function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic cin, input logic [3:0] mode);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        logic       v;
        s = '0;
        c = 1'b0;
        v = 1'b0;
        case (mode)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b} + {8'b0, cin};
                r = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'd1: begin
                s = {1'b0, a} - {1'b0, b} - {8'b0, cin};
                r = s[7:0];
                c = s[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            default: r = ~a;
        endcase
        return {v, (r == 8'h00), r[7], c, r};
    endfunction

    always_comb begin
        {alu_ovf, alu_zero, alu_neg, alu_carry, alu_result} =
            alu_ref(alu_a, alu_b, alu_cin, alu_mode);
    end

    typedef struct {
        logic [7:0] res;
        logic [3:0] flg;
        logic       cq;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic       m_carry = 1'b0;
    int         m_ops = 0;
    logic [7:0] last_res;
    logic [3:0] last_flg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic predict(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic chain, input logic [3:0] mode);
        logic [11:0] r;
        exp_t        e;
        r = alu_ref(a, b, chain ? m_carry : cin, mode);
        e.res = r[7:0];
        e.flg = r[11:8];
        e.cq  = r[8];
        sb.push_back(e);
        m_carry = r[8];
    endtask

    // Returns #1 after the accept edge (sequencer now in ISSUE).
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic chain, input logic [3:0] mode);
        int unsigned n;
        predict(a, b, cin, chain, mode);
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_chain = chain; cmd_mode = mode;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp();
        int unsigned n;
        exp_t        e;
        rsp_ready = 1'b1;
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("result", 32'(rsp_result), 32'(e.res));
            check("flags", 32'(rsp_flags), 32'(e.flg));
            check("carry_q", 32'(carry_q), 32'(e.cq));
            last_res = rsp_result;
            last_flg = rsp_flags;
            @(posedge clk);
            #1;
            if (m_ops < (1 << CNT_W) - 1) m_ops++;
        end
        rsp_ready = 1'b0;
        check("ops_done", 32'(ops_done), 32'(m_ops));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hold_res;
        logic [3:0] hold_flg;
        logic       seen;
        exp_t       e;
        int unsigned n;

        // Reset state
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_carry_q", 32'(carry_q), 32'd0);
        check("rst_ops_done", 32'(ops_done), 32'd0);
        check("rst_sticky", 32'(sticky_ovf), 32'd0);
        check("rst_alu", {11'd0, alu_a, alu_b, alu_cin, alu_mode}, 32'd0);
        check("rst_rsp", {20'd0, rsp_result, rsp_flags}, 32'd0);

        // Signed overflow add, with latency check
        send(8'h7F, 8'h01, 1'b0, 1'b0, 4'd0);
        check("lat_issue", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_resp", 32'(rsp_valid), 32'd1);
        get_rsp();
        check("add_res", 32'(last_res), 32'h80);
        check("add_flg", 32'(last_flg), 32'b1010);
        check("sticky_set", 32'(sticky_ovf), 32'd1);

        // Clear sticky while idle
        @(negedge clk); sticky_clr = 1'b1;
        @(negedge clk); sticky_clr = 1'b0;
        check("sticky_clr", 32'(sticky_ovf), 32'd0);

        // 16-bit add 0x01FF + 0x0001
        send(8'hFF, 8'h01, 1'b0, 1'b0, 4'd0);
        get_rsp();
        check("add16_lo_flg", 32'(last_flg), 32'b0101);
        check("add16_cq", 32'(carry_q), 32'd1);
        send(8'h01, 8'h00, 1'b0, 1'b1, 4'd0);
        check("chain_cin", 32'(alu_cin), 32'd1);
        get_rsp();
        check("add16_hi", {last_res, last_flg}, {8'h02, 4'b0000});

        // 16-bit subtract 0x0100 - 0x0001
        send(8'h00, 8'h01, 1'b0, 1'b0, 4'd1);
        get_rsp();
        check("sub16_lo", 32'(last_res), 32'hFF);
        check("sub16_borrow", 32'(carry_q), 32'd1);
        send(8'h01, 8'h00, 1'b0, 1'b1, 4'd1);
        get_rsp();
        check("sub16_hi", 32'(last_res), 32'h00);
        check("sub16_zero", 32'(last_flg[2]), 32'd1);
        check("sub16_cq", 32'(carry_q), 32'd0);

        // Overflow capture and clear on the same edge: set wins
        @(negedge clk); sticky_clr = 1'b1;
        send(8'h80, 8'h01, 1'b0, 1'b0, 4'd1);
        @(posedge clk); #1;
        check("sticky_set_wins", 32'(sticky_ovf), 32'd1);
        sticky_clr = 1'b0;
        get_rsp();

        // Backpressure: response held, pending command waits
        send(8'h3C, 8'h0F, 1'b0, 1'b0, 4'd2);
        cmd_a = 8'h55; cmd_b = 8'h0F; cmd_cin = 1'b0; cmd_chain = 1'b0; cmd_mode = 4'd4;
        cmd_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        e = sb.pop_front();
        check("bp_result", 32'(rsp_result), 32'(e.res));
        hold_res = rsp_result;
        hold_flg = rsp_flags;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {rsp_valid, cmd_ready, rsp_flags, rsp_result},
                  {1'b1, 1'b0, hold_flg, hold_res});
        end
        predict(8'h55, 8'h0F, 1'b0, 1'b0, 4'd4);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        m_ops++;
        check("bp_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        check("bp_accept", 32'(cmd_ready), 32'd0);
        check("bp_alu_a", 32'(alu_a), 32'h55);
        cmd_valid = 1'b0;
        get_rsp();
        check("bp_xor", 32'(last_res), 32'h5A);

        // Reset during ISSUE aborts the operation
        send(8'hFF, 8'h01, 1'b0, 1'b0, 4'd0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        void'(sb.pop_back());
        m_carry = 1'b0;
        m_ops = 0;
        seen = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        check("abort_carry", 32'(carry_q), 32'd0);
        check("abort_ops", 32'(ops_done), 32'd0);
        send(8'h03, 8'h04, 1'b0, 1'b0, 4'd0);
        get_rsp();
        check("post_abort", 32'(last_res), 32'h07);

        // Random mix, long enough to saturate the small counter
        for (int unsigned i = 0; i < 20; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
            get_rsp();
        end
        check("ops_saturated", 32'(ops_done), 32'((1 << CNT_W) - 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
